mem_access_unit: RTL

- Parametrised successor to the single-cycle memory stage, placed between execute (ALU) and writeback.
- Adds byte/half/word/double sizing, lane strobes, load sign/zero extension, a memory-ready wait handshake and misalignment detection.
- Keeps the kick-up token protocol: one ALU_kick_up in produces exactly one MEM_kick_up out.

---
 rtl/mem_access_unit.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Memory stage between execute and writeback. It accepts one ALU_kick_up
//   token and returns exactly one MEM_kick_up token. In between it runs a
//   sized data-memory access: byte, half, word or double. It drives lane
//   strobes and lane-replicated store data, sign/zero-extends loads and waits
//   on a memory-ready handshake. Misaligned accesses are faulted without
//   touching memory.
//
// Parameters:
//   XLEN           data width, 32 or 64
//   ADDR_W         address width
//   TIMEOUT_CYCLES ready-wait limit (only with MEM_TIMEOUT_EN)
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   When defined, a WRITE/READ that sees no Data_mem_ready within
//   TIMEOUT_CYCLES cycles is aborted and completes with Bus_error=1.
//   When undefined, the unit waits forever and Bus_error is tied to 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ALU_result                 effective address
//   ALU_kick_up                one-cycle token from execute
//   Write_data                 store data
//   Controller_memwrite/read   store / load instruction
//   Controller_funct3          access size [1:0] and unsigned flag [2]
//   Data_mem_write_*           write request, aligned address, data, strobes
//   Data_mem_read_*            read request, aligned address, return data
//   Data_mem_ready             memory completed the current request
//   Load_data                  extended load result (held between loads)
//   Misaligned, Bus_error      fault flags, valid with MEM_kick_up
//   MEM_kick_up                one-cycle completion token
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   ALU_result,
    input  logic                ALU_kick_up,
    input  logic [XLEN-1:0]     Write_data,
    input  logic                Controller_memwrite,
    input  logic                Controller_memread,
    input  logic [2:0]          Controller_funct3,
    output logic                Data_mem_write_enable,
    output logic [ADDR_W-1:0]   Data_mem_write_addr,
    output logic [XLEN-1:0]     Data_mem_write_data,
    output logic [XLEN/8-1:0]   Data_mem_write_strb,
    output logic                Data_mem_read_enable,
    output logic [ADDR_W-1:0]   Data_mem_read_addr,
    input  logic [XLEN-1:0]     Data_mem_read_data,
    input  logic                Data_mem_ready,
    output logic [XLEN-1:0]     Load_data,
    output logic                Misaligned,
    output logic                Bus_error,
    output logic                MEM_kick_up
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                fault_q, fault_d;
    logic [XLEN-1:0]     load_q, load_d;
    logic                kickOut_q, kickOut_d;
    logic                misOut_q, misOut_d;

    logic                faultIn;
    logic [OFFW-1:0]     offset;
    logic [3:0]          nBytes;
    logic [NB-1:0]       sizeMask;
    logic [NB-1:0]       laneStrb;
    logic [XLEN-1:0]     laneData;
    logic [XLEN-1:0]     readShifted;
    logic [XLEN-1:0]     readExtended;
    logic [ADDR_W-1:0]   alignedAddr;

`ifdef MEM_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNTW-1:0]     waitCnt_q, waitCnt_d;
    logic                busErr_q, busErr_d;
    logic                busErrOut_q, busErrOut_d;
    logic                timeoutHit;

    // The counter is zero in the first cycle of WRITE/READ, so the request is
    // visible for exactly TIMEOUT_CYCLES cycles before the abort edge.
    assign timeoutHit = (waitCnt_q == CNTW'(TIMEOUT_CYCLES - 1));

    // Timeout bookkeeping registers; cleared by reset like the rest of the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt_q   <= '0;
            busErr_q    <= 1'b0;
            busErrOut_q <= 1'b0;
        end else begin
            waitCnt_q   <= waitCnt_d;
            busErr_q    <= busErr_d;
            busErrOut_q <= busErrOut_d;
        end
    end
`endif

    // Alignment fault check on the incoming request. A double access is
    // always a fault on a 32-bit datapath.
    always_comb begin
        faultIn = 1'b0;
        unique case (Controller_funct3[1:0])
            2'b01:   faultIn = ALU_result[0];
            2'b10:   faultIn = |ALU_result[1:0];
            2'b11:   faultIn = (|ALU_result[2:0]) || (XLEN == 32);
            default: faultIn = 1'b0;
        endcase
    end

    // Lane geometry of the latched access.
    assign offset      = addr_q[OFFW-1:0];
    assign nBytes      = 4'd1 << funct3_q[1:0];
    assign alignedAddr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    // Strobe is a size-wide mask moved up to the addressed byte. Store data
    // repeats the low size bytes across every lane. The access is aligned,
    // so each lane picks byte (lane mod size).
    always_comb begin
        sizeMask = '0;
        laneData = '0;
        for (int i = 0; i < NB; i++) begin
            int lane;
            sizeMask[i] = (i < int'(nBytes));
            lane = i & (int'(nBytes) - 1);
            laneData[8*i +: 8] = wdata_q[8*lane +: 8];
        end
        laneStrb = sizeMask << offset;
    end

    // Move the addressed lane down to bit 0, then extend it by size. The
    // width casts of signed values perform the sign extension.
    always_comb begin
        readShifted  = Data_mem_read_data >> {offset, 3'b000};
        readExtended = readShifted;
        unique case (funct3_q[1:0])
            2'b00:   readExtended = funct3_q[2] ? XLEN'(readShifted[7:0])
                                                : XLEN'($signed(readShifted[7:0]));
            2'b01:   readExtended = funct3_q[2] ? XLEN'(readShifted[15:0])
                                                : XLEN'($signed(readShifted[15:0]));
            2'b10:   readExtended = funct3_q[2] ? XLEN'(readShifted[31:0])
                                                : XLEN'($signed(readShifted[31:0]));
            default: readExtended = readShifted;
        endcase
    end

    // State and datapath registers. Reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            fault_q   <= 1'b0;
            load_q    <= '0;
            kickOut_q <= 1'b0;
            misOut_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            fault_q   <= fault_d;
            load_q    <= load_d;
            kickOut_q <= kickOut_d;
            misOut_q  <= misOut_d;
        end
    end

    // Next-state logic. Faults win over everything, and a store wins over a
    // load. An instruction without a memory access goes straight to DONE.
    // The completion token and flags are registered out of DONE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        fault_d   = fault_q;
        load_d    = load_q;
        kickOut_d = 1'b0;
        misOut_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        waitCnt_d   = waitCnt_q;
        busErr_d    = busErr_q;
        busErrOut_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (ALU_kick_up) begin
                    addr_d   = ALU_result;
                    wdata_d  = Write_data;
                    funct3_d = Controller_funct3;
                    fault_d  = faultIn & (Controller_memread | Controller_memwrite);
`ifdef MEM_TIMEOUT_EN
                    waitCnt_d = '0;
                    busErr_d  = 1'b0;
`endif
                    if (faultIn && (Controller_memread || Controller_memwrite)) begin
                        state_d = DONE;
                        if (Controller_memread && !Controller_memwrite) begin
                            load_d = '0;
                        end
                    end else if (Controller_memwrite) begin
                        state_d = WRITE;
                    end else if (Controller_memread) begin
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (Data_mem_ready) begin
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeoutHit) begin
                    state_d  = DONE;
                    busErr_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
`endif
            end
            READ: begin
                if (Data_mem_ready) begin
                    load_d  = readExtended;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeoutHit) begin
                    load_d   = '0;
                    state_d  = DONE;
                    busErr_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d   = IDLE;
                kickOut_d = 1'b1;
                misOut_d  = fault_q;
`ifdef MEM_TIMEOUT_EN
                busErrOut_d = busErr_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Request outputs follow the state directly, so they drop on the same
    // edge that samples Data_mem_ready. They read as zero when idle.
    always_comb begin
        Data_mem_write_enable = (state_q == WRITE);
        Data_mem_write_addr   = (state_q == WRITE) ? alignedAddr : '0;
        Data_mem_write_data   = (state_q == WRITE) ? laneData    : '0;
        Data_mem_write_strb   = (state_q == WRITE) ? laneStrb    : '0;
        Data_mem_read_enable  = (state_q == READ);
        Data_mem_read_addr    = (state_q == READ)  ? alignedAddr : '0;
        Load_data             = load_q;
        Misaligned            = misOut_q;
        MEM_kick_up           = kickOut_q;
`ifdef MEM_TIMEOUT_EN
        Bus_error             = busErrOut_q;
`else
        Bus_error             = 1'b0;
`endif
    end

endmodule
